// File: rtl/counter_mode_sched.sv
// counter_mode_sched: runs an external 3-bit counter through N binary wraps then M gray wraps,
// checking that every count follows its predecessor in the active code order.
module counter_mode_sched #(
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] bin_passes,
  input  logic [PASS_W-1:0] gray_passes,
  input  logic [2:0]        count,
  output logic              cnt_reset,
  output logic              cnt_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);
  typedef enum logic [2:0] {IDLE, BIN_RUN, SWITCH, GRAY_RUN, DONE} state_t;
  state_t            r_state, w_next;
  logic [PASS_W-1:0] r_bin, r_gray, r_pass, w_pass_inc;
  logic [2:0]        r_count_q, w_gbin, w_ginc, w_succ;
  logic              r_err, r_run_d, w_run, w_gray, w_accept, w_wrap, w_bad;

  assign w_gray     = r_state == GRAY_RUN;
  assign w_run      = r_state == BIN_RUN || w_gray;
  assign w_accept   = r_state == IDLE && start;
  assign w_wrap     = w_run && count == 3'b000 && r_count_q == (w_gray ? 3'b100 : 3'b111);
  assign w_pass_inc = r_pass + PASS_W'(1);
  // gray successor: decode to binary, increment, re-encode
  assign w_gbin     = {r_count_q[2], ^r_count_q[2:1], ^r_count_q};
  assign w_ginc     = w_gbin + 3'd1;
  assign w_succ     = w_gray ? (w_ginc ^ (w_ginc >> 1)) : r_count_q + 3'd1;
  // the first run cycle still sees the held 000, so it is not checked
  assign w_bad      = w_run && r_run_d && !abort && count != w_succ;
  assign err        = r_err;
  assign pass_cnt   = r_pass;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_count_q <= 3'b000;
      r_bin     <= '0;
      r_gray    <= '0;
      r_pass    <= '0;
      r_err     <= 1'b0;
      r_run_d   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count_q <= count;
      r_run_d   <= w_run;
      if (w_accept) begin
        r_bin  <= bin_passes;
        r_gray <= gray_passes;
      end
      r_pass <= (w_accept || (r_state == SWITCH && !abort)) ? '0 :
                (w_wrap && !abort) ? w_pass_inc : r_pass;
      r_err  <= w_accept ? 1'b0 : r_err | w_bad;
    end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = bin_passes != '0 ? BIN_RUN : gray_passes != '0 ? SWITCH : DONE;
      BIN_RUN:  w_next = abort ? IDLE : (w_wrap && w_pass_inc == r_bin) ? SWITCH : BIN_RUN;
      SWITCH:   w_next = abort ? IDLE : r_gray != '0 ? GRAY_RUN : DONE;
      GRAY_RUN: w_next = abort ? IDLE : (w_wrap && w_pass_inc == r_gray) ? DONE : GRAY_RUN;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_reset = r_state == IDLE || r_state == SWITCH || r_state == DONE;
    cnt_mode  = r_state == SWITCH || w_gray;
    busy      = r_state != IDLE;
    done      = r_state == DONE;
  end
endmodule

// File: tb/tb_counter_mode_sched.sv
// tb_counter_mode_sched: scoreboard bench pairing the scheduler with a 3-bit binary/gray counter model.
module tb_counter_mode_sched;
  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, skip_010 = 1'b0;
  logic [3:0] bin_passes = 4'd0, gray_passes = 4'd0;
  logic [2:0] count = 3'd0;
  logic       cnt_reset, cnt_mode, busy, done, err;
  logic [3:0] pass_cnt;
  logic [11:0] q[$];
  logic [11:0] obs, exp_v;
  logic [2:0] gseq [9] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
  int n_cmp = 0, n_bad = 0;
  // {cnt_reset, cnt_mode, busy, done} per state
  localparam logic [3:0] IDLE_O = 4'b1000, BIN_O = 4'b0010, SW_O = 4'b1110, GRAY_O = 4'b0110, DONE_O = 4'b1011;

  counter_mode_sched #(.PASS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .bin_passes(bin_passes), .gray_passes(gray_passes), .count(count),
    .cnt_reset(cnt_reset), .cnt_mode(cnt_mode), .busy(busy), .done(done),
    .err(err), .pass_cnt(pass_cnt)
  );

  assign obs = {cnt_reset, cnt_mode, busy, done, err, pass_cnt, count};

  always #5 clk = ~clk;

  function automatic logic [2:0] gray_next(input logic [2:0] g);
    case (g)
      3'd0: return 3'd1;
      3'd1: return 3'd3;
      3'd3: return 3'd2;
      3'd2: return 3'd6;
      3'd6: return 3'd7;
      3'd7: return 3'd5;
      3'd5: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge clk)
    if (cnt_reset) count <= 3'd0;
    else if (cnt_mode) count <= gray_next(count);
    else count <= (skip_010 && count == 3'd1) ? 3'd3 : count + 3'd1;

  function automatic void put(input logic [3:0] ctl, input int e, input int p, input int c);
    q.push_back({ctl, 1'(e), 4'(p), 3'(c)});
  endfunction

  task automatic test_reset();
    #2 reset = 1'b1;
    start = 1'b1;
    bin_passes = 4'd3;
    #1;
    n_cmp++;
    if (obs !== {IDLE_O, 1'b0, 4'd0, 3'd0}) begin n_bad++; $display("FAIL reset_async: got %h expected %h", obs, {IDLE_O, 1'b0, 4'd0, 3'd0}); end
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE_O, 1'b0, 4'd0, 3'd0}) begin n_bad++; $display("FAIL reset_held: got %h expected %h", obs, {IDLE_O, 1'b0, 4'd0, 3'd0}); end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE_O, 1'b0, 4'd0, 3'd0}) begin n_bad++; $display("FAIL reset_idle: got %h expected %h", obs, {IDLE_O, 1'b0, 4'd0, 3'd0}); end
  endtask

  task automatic test_bin_gray();
    bin_passes = 4'd1;
    gray_passes = 4'd1;
    for (int i = 0; i < 9; i++) put(BIN_O, 0, 0, i % 8);
    put(SW_O, 0, 1, 1);
    for (int i = 0; i < 9; i++) put(GRAY_O, 0, 0, gseq[i]);
    put(DONE_O, 0, 1, 1);
    put(IDLE_O, 0, 1, 0);
    put(IDLE_O, 0, 1, 0);
    start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL bin_gray: got %h expected %h", obs, exp_v); end
    end
  endtask

  task automatic test_gray_only();
    bin_passes = 4'd0;
    gray_passes = 4'd2;
    put(SW_O, 0, 0, 0);
    for (int i = 0; i < 9; i++) put(GRAY_O, 0, 0, gseq[i]);
    for (int i = 1; i < 9; i++) put(GRAY_O, 0, 1, gseq[i]);
    put(DONE_O, 0, 2, 1);
    put(IDLE_O, 0, 2, 0);
    start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL gray_only: got %h expected %h", obs, exp_v); end
    end
  endtask

  task automatic test_zero_passes();
    bin_passes = 4'd0;
    gray_passes = 4'd0;
    put(DONE_O, 0, 0, 0);
    put(IDLE_O, 0, 0, 0);
    put(IDLE_O, 0, 0, 0);
    start = 1'b1;
    abort = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      exp_v = q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL zero_passes: got %h expected %h", obs, exp_v); end
    end
  endtask

  task automatic test_seq_error();
    logic [2:0] bseq [8] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    bin_passes = 4'd1;
    gray_passes = 4'd0;
    skip_010 = 1'b1;
    for (int i = 0; i < 8; i++) put(BIN_O, i >= 3, 0, bseq[i]);
    put(SW_O, 1, 1, 1);
    put(DONE_O, 1, 0, 0);
    put(IDLE_O, 1, 0, 0);
    start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL seq_error: got %h expected %h", obs, exp_v); end
    end
    skip_010 = 1'b0;
    bin_passes = 4'd0;
    put(DONE_O, 0, 0, 0);
    put(IDLE_O, 0, 0, 0);
    start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL err_clear: got %h expected %h", obs, exp_v); end
    end
  endtask

  task automatic test_abort();
    int i = 0;
    bin_passes = 4'd1;
    gray_passes = 4'd1;
    for (int k = 0; k < 3; k++) put(BIN_O, 0, 0, k);
    put(IDLE_O, 0, 0, 3);
    put(IDLE_O, 0, 0, 0);
    start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      exp_v = q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL abort: got %h expected %h", obs, exp_v); end
      start = i == 1;
      abort = i == 2;
      i++;
    end
  endtask

  task automatic test_async_reset();
    bin_passes = 4'd0;
    gray_passes = 4'd2;
    put(SW_O, 0, 0, 0);
    for (int i = 0; i < 9; i++) put(GRAY_O, 0, 0, gseq[i]);
    put(GRAY_O, 0, 1, 1);
    put(GRAY_O, 0, 1, 3);
    start = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      exp_v = q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pre_reset: got %h expected %h", obs, exp_v); end
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs[11:3] !== {IDLE_O, 1'b0, 4'd0}) begin n_bad++; $display("FAIL async_reset: got %h expected %h", obs[11:3], {IDLE_O, 1'b0, 4'd0}); end
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE_O, 1'b0, 4'd0, 3'd2}) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", obs, {IDLE_O, 1'b0, 4'd0, 3'd2}); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== {IDLE_O, 1'b0, 4'd0, 3'd0}) begin n_bad++; $display("FAIL reset_resume: got %h expected %h", obs, {IDLE_O, 1'b0, 4'd0, 3'd0}); end
    bin_passes = 4'd0;
    gray_passes = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (obs !== {DONE_O, 1'b0, 4'd0, 3'd0}) begin n_bad++; $display("FAIL restart: got %h expected %h", obs, {DONE_O, 1'b0, 4'd0, 3'd0}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bin_gray();
    test_gray_only();
    test_zero_passes();
    test_seq_error();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/counter_mode_sched.md
COUNTER_MODE_SCHED -- requirements
Module: counter_mode_sched

Interface
REQ-001 Parameter: PASS_W, 4, width of pass-count fields.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-004 Port: start  input  1  request one binary-then-gray run; accepted only in IDLE.
REQ-005 Port: abort  input  1  terminate the current run.
REQ-006 Port: bin_passes  input  PASS_W  full binary wraps requested; sampled on start acceptance.
REQ-007 Port: gray_passes  input  PASS_W  full gray wraps requested; sampled on start acceptance.
REQ-008 Port: count  input  3  current value of the 3-bit binary/gray counter.
REQ-009 Port: cnt_reset  output  1  drives counter reset; counter holds 000 while high.
REQ-010 Port: cnt_mode  output  1  drives counter mode; 0 = binary, 1 = gray.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done  output  1  one-cycle pulse on normal run completion.
REQ-013 Port: err  output  1  sticky sequence-error flag.
REQ-014 Port: pass_cnt  output  PASS_W  wraps completed in the current phase.

Function
REQ-015 States: IDLE, BIN_RUN, SWITCH, GRAY_RUN, DONE; outputs registered.
REQ-016 Outputs per state: IDLE cnt_reset=1, cnt_mode=0; BIN_RUN 0/0; SWITCH 1/1; GRAY_RUN 0/1; DONE 1/0.
REQ-017 IDLE + start=1: latch both pass fields, clear err and pass_cnt; next state BIN_RUN if bin_passes!=0, else SWITCH if gray_passes!=0, else DONE.
REQ-018 start while busy=1 is ignored; no queuing.
REQ-019 count_q registers count every cycle; wrap event = count_q equals the phase's last code (binary 111, gray 100) and count=000.
REQ-020 In BIN_RUN/GRAY_RUN, each wrap event increments pass_cnt.
REQ-021 BIN_RUN: when the increment makes pass_cnt equal the latched bin_passes, next state SWITCH.
REQ-022 SWITCH: exactly one cycle; clears pass_cnt; next GRAY_RUN if latched gray_passes!=0, else DONE.
REQ-023 GRAY_RUN: when the increment makes pass_cnt equal the latched gray_passes, next state DONE.
REQ-024 DONE: exactly one cycle; done=1; next IDLE; pass_cnt holds its final value until the next start.
REQ-025 Sequence check: in the first cycle of BIN_RUN/GRAY_RUN after cnt_reset falls, the check is skipped; thereafter count must equal successor(count_q), otherwise err=1.
REQ-026 Binary successor: count_q+1 mod 8 (111 wraps to 000).
REQ-027 Gray successor order: 000,001,011,010,110,111,101,100, then 000.
REQ-028 err stays set until the next accepted start or reset; an error does not stop the run.
REQ-029 abort=1 in any busy state: next state IDLE, done not pulsed, err and pass_cnt held; abort in IDLE has no effect.
REQ-030 abort and a completing wrap in the same cycle: abort wins; no done.
REQ-031 start and abort together in IDLE: start is accepted and abort is ignored.

Reset
REQ-032 reset=1 sets state IDLE, cnt_reset=1, cnt_mode=0, busy=0, done=0, err=0, pass_cnt=0, count_q=000 and the latched pass fields to 0, asynchronously.
REQ-033 reset asserted mid-run discards the run without a done pulse; operation resumes from IDLE on the first edge after deassertion.

Verification
REQ-034 Bench connects the block to a compliant 3-bit binary/gray counter model and covers these scenarios:
REQ-035 bin_passes=1, gray_passes=1, start -> 8 binary counts 000..111, SWITCH with cnt_reset=1, 8 gray counts 000..100, one done pulse, err=0.
REQ-036 bin_passes=0, gray_passes=2, start -> BIN_RUN skipped, two gray wraps, pass_cnt=2 at done.
REQ-037 Both passes 0 -> IDLE, DONE, IDLE; done one cycle; cnt_reset never falls.
REQ-038 Counter model forced to skip 010 during a binary run -> err=1 held through done, then cleared by the next start.
REQ-039 abort during the 3rd binary count -> IDLE next cycle, cnt_reset=1, no done; start issued while busy is ignored.
REQ-040 Async reset pulse mid-GRAY_RUN, asserted between clock edges -> outputs reach reset values before the next edge.
